kaly_sub_sched: RTL
===================

KALY_SUB_SCHED -- requirements
Module: kaly_sub_sched

Interface
REQ-001 Parameter KEY_PRI, default 0, SHALL select arbitration: 0 = round-robin, 1 = key channel has strict priority.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 blk_start  input  1  SHALL request substitution of blk_in.
REQ-005 blk_in  input  128  SHALL carry the data block; byte k = bits [8k+7:8k].
REQ-006 blk_busy  output  1  SHALL indicate the block channel holds an accepted, unfinished job.
REQ-007 blk_done  output  1  SHALL be a one-cycle completion pulse for the block channel.
REQ-008 blk_out  output  128  SHALL carry the substituted block.
REQ-009 key_start  input  1  SHALL request substitution of key_in.
REQ-010 key_in  input  32  SHALL carry the key-schedule word; byte k = bits [8k+7:8k].
REQ-011 key_busy  output  1  SHALL indicate the key channel holds an accepted, unfinished job.
REQ-012 key_done  output  1  SHALL be a one-cycle completion pulse for the key channel.
REQ-013 key_out  output  32  SHALL carry the substituted word.

Function
REQ-014 Block SHALL instantiate exactly one kaly_sbox2; no other S-box logic is permitted.
REQ-015 Each channel SHALL have a working register, a byte index (4-bit block, 2-bit key) and a busy flag.
REQ-016 A start SHALL be accepted only at an edge where that channel's busy is 0; it then loads input into the working register, clears the index and sets busy.
REQ-017 A start sampled while busy is 1 SHALL be ignored, with no effect on the running job.
REQ-018 Each edge, the arbiter SHALL grant the S-box to at most one busy channel; an idle channel is never granted.
REQ-019 Granted channel SHALL have byte [index] replaced by the S-box output of that byte and index incremented, in the same edge.
REQ-020 Bytes SHALL be processed in ascending order, byte 0 first.
REQ-021 KEY_PRI=0: if both channels are busy, grant SHALL go to the channel not granted last; a last-grant register resets to "key", so the block channel wins the first contention.
REQ-022 KEY_PRI=1: key channel SHALL be granted whenever busy; block channel only when key is idle.
REQ-023 At the edge writing the final byte (15 block / 3 key), that channel SHALL clear busy and set done; done SHALL clear at the next edge.
REQ-024 Uncontended latency SHALL be 16 edges (block) / 4 edges (key) from the accepting edge to done=1.
REQ-025 blk_out/key_out SHALL be driven directly from the working registers; values are valid while done=1 and SHALL hold until the next accepted start.
REQ-026 A start sampled at the edge after done (busy=0) SHALL be accepted; no dead cycle is required between jobs.
REQ-027 Both starts at the same edge SHALL both be accepted.
REQ-028 The channels SHALL be independent; one channel's start or done SHALL never alter the other's data or index.

Reset
REQ-029 rst_n=0 SHALL immediately clear all busy and done flags, indices, working registers (outputs 0) and set last-grant to "key".
REQ-030 Reset mid-job SHALL abort the job with no done pulse; the first start after release SHALL be accepted normally.

Verification
REQ-031 blk_in all 0x00, start, KEY_PRI=0 -> blk_done 16 edges later, blk_out = 0xcece...ce (16 bytes), blk_busy high 16 cycles.
REQ-032 key_in=0x00010203, start -> key_done 4 edges later, key_out=0xcebbeb92; then key_in=0xff83aa01 -> 0xd700ffbb.
REQ-033 KEY_PRI=0, both start at edge E0 with blk_in all 0xff and key_in=0 -> grants alternate blk,key from E1; key_done after E8 (key_out=0xcecececece... 32-bit 0xcececece); blk_done after E20, blk_out all 0xd7.
REQ-034 KEY_PRI=1, same stimulus -> key_done after E4; blk_done after E20.
REQ-035 blk_start re-pulsed at E5 of a running job with different data -> ignored; blk_out matches first data; back-to-back start on the edge after done -> accepted, done 16 edges later.
REQ-036 rst_n pulsed low at E7 of a block job -> all outputs 0 asynchronously, no blk_done; new start after release completes in 16 edges.

Source files
------------

// File: rtl/kaly_sub_sched.sv
// Two-channel byte substitution scheduler: a 128-bit block channel and a 32-bit
// key channel time-share one kaly_sbox2, one byte per clock edge.

module kaly_sbox2 (
    input  logic [7:0] din,
    output logic [7:0] dout_c
);

    localparam logic [7:0] SBOX [256] = '{
        8'hce, 8'hbb, 8'heb, 8'h92, 8'hea, 8'hcb, 8'h13, 8'hc1, 8'he9, 8'h3a, 8'hd6, 8'hb2, 8'hd2, 8'h90, 8'h17, 8'hf8,
        8'h42, 8'h15, 8'h56, 8'hb4, 8'h65, 8'h1c, 8'h88, 8'h43, 8'hc5, 8'h5c, 8'h36, 8'hba, 8'hf5, 8'h57, 8'h67, 8'h8d,
        8'h31, 8'hf6, 8'h64, 8'h58, 8'h9e, 8'hf4, 8'h22, 8'haa, 8'h75, 8'h0f, 8'h02, 8'hb1, 8'hdf, 8'h6d, 8'h73, 8'h4d,
        8'h7c, 8'h26, 8'h2e, 8'hf7, 8'h08, 8'h5d, 8'h44, 8'h3e, 8'h9f, 8'h14, 8'hc8, 8'hae, 8'h54, 8'h10, 8'hd8, 8'hbc,
        8'h1a, 8'h6b, 8'h69, 8'hf3, 8'hbd, 8'h33, 8'hab, 8'hfa, 8'hd1, 8'h9b, 8'h68, 8'h4e, 8'h16, 8'h95, 8'h91, 8'hee,
        8'h4c, 8'h63, 8'h8e, 8'h5b, 8'hcc, 8'h3c, 8'h19, 8'ha1, 8'h81, 8'h49, 8'h7b, 8'hd9, 8'h6f, 8'h37, 8'h60, 8'hca,
        8'he7, 8'h2b, 8'h48, 8'hfd, 8'h96, 8'h45, 8'hfc, 8'h41, 8'h12, 8'h0d, 8'h79, 8'he5, 8'h89, 8'h8c, 8'he3, 8'h20,
        8'h30, 8'hdc, 8'hb7, 8'h6c, 8'h4a, 8'hb5, 8'h3f, 8'h97, 8'hd4, 8'h62, 8'h2d, 8'h06, 8'ha4, 8'ha5, 8'h83, 8'h5f,
        8'h2a, 8'hda, 8'hc9, 8'h00, 8'h7e, 8'ha2, 8'h55, 8'hbf, 8'h11, 8'hd5, 8'h9c, 8'hcf, 8'h0e, 8'h0a, 8'h3d, 8'h51,
        8'h7d, 8'h93, 8'h1b, 8'hfe, 8'hc4, 8'h47, 8'h09, 8'h86, 8'h0b, 8'h8f, 8'h9d, 8'h6a, 8'h07, 8'hb9, 8'hb0, 8'h98,
        8'h18, 8'h32, 8'h71, 8'h4b, 8'hef, 8'h3b, 8'h70, 8'ha0, 8'he4, 8'h40, 8'hff, 8'hc3, 8'ha9, 8'he6, 8'h78, 8'hf9,
        8'h8b, 8'h46, 8'h80, 8'h1e, 8'h38, 8'he1, 8'hb8, 8'ha8, 8'he0, 8'h0c, 8'h23, 8'h76, 8'h1d, 8'h25, 8'h24, 8'h05,
        8'hf1, 8'h6e, 8'h94, 8'h28, 8'h9a, 8'h84, 8'he8, 8'ha3, 8'h4f, 8'h77, 8'hd3, 8'h85, 8'he2, 8'h52, 8'hf2, 8'h82,
        8'h50, 8'h7a, 8'h2f, 8'h74, 8'h53, 8'hb3, 8'h61, 8'haf, 8'h39, 8'h35, 8'hde, 8'hcd, 8'h1f, 8'h99, 8'hac, 8'had,
        8'h72, 8'h2c, 8'hdd, 8'hd0, 8'h87, 8'hbe, 8'h5e, 8'ha6, 8'hec, 8'h04, 8'hc6, 8'h03, 8'h34, 8'hfb, 8'hdb, 8'h59,
        8'hb6, 8'hc2, 8'h01, 8'hf0, 8'h5a, 8'hed, 8'ha7, 8'h66, 8'h21, 8'h7f, 8'h8a, 8'h27, 8'hc7, 8'hc0, 8'h29, 8'hd7
    };

    always_comb begin
        dout_c = SBOX[din];
    end

endmodule

module kaly_sub_sched #(
    parameter int unsigned KEY_PRI = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_start,
    input  logic [127:0] blk_in,
    output logic         blk_busy,
    output logic         blk_done,
    output logic [127:0] blk_out,
    input  logic         key_start,
    input  logic [31:0]  key_in,
    output logic         key_busy,
    output logic         key_done,
    output logic [31:0]  key_out
);

    localparam int unsigned BLK_BYTES = 16;
    localparam int unsigned KEY_BYTES = 4;
    localparam int unsigned BLK_IDX_W = 4;
    localparam int unsigned KEY_IDX_W = 2;

    logic [BLK_IDX_W-1:0] blk_idx;
    logic [KEY_IDX_W-1:0] key_idx;
    logic                 last_key;
    logic                 grant_blk_c;
    logic                 grant_key_c;
    logic [7:0]           sbox_in_c;
    logic [7:0]           sbox_out_c;

    // Arbiter: strict key priority, or alternate on contention (last_key=1 means key won last)
    always_comb begin
        grant_blk_c = 1'b0;
        grant_key_c = 1'b0;
        if (KEY_PRI != 0) begin
            grant_key_c = key_busy;
            grant_blk_c = blk_busy && !key_busy;
        end else if (blk_busy && key_busy) begin
            grant_blk_c = last_key;
            grant_key_c = !last_key;
        end else begin
            grant_blk_c = blk_busy;
            grant_key_c = key_busy;
        end
    end

    always_comb begin
        sbox_in_c = grant_key_c ? key_out[{key_idx, 3'b000} +: 8]
                                : blk_out[{blk_idx, 3'b000} +: 8];
    end

    kaly_sbox2 u_sbox (
        .din    (sbox_in_c),
        .dout_c (sbox_out_c)
    );

    // Block channel: the working register doubles as blk_out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_out  <= '0;
            blk_idx  <= '0;
            blk_busy <= 1'b0;
            blk_done <= 1'b0;
        end else begin
            blk_done <= 1'b0;
            if (blk_start && !blk_busy) begin
                blk_out  <= blk_in;
                blk_idx  <= '0;
                blk_busy <= 1'b1;
            end else if (grant_blk_c) begin
                blk_out[{blk_idx, 3'b000} +: 8] <= sbox_out_c;
                blk_idx <= blk_idx + 1'b1;
                if (blk_idx == BLK_IDX_W'(BLK_BYTES - 1)) begin
                    blk_busy <= 1'b0;
                    blk_done <= 1'b1;
                end
            end
        end
    end

    // Key channel: the working register doubles as key_out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_out  <= '0;
            key_idx  <= '0;
            key_busy <= 1'b0;
            key_done <= 1'b0;
        end else begin
            key_done <= 1'b0;
            if (key_start && !key_busy) begin
                key_out  <= key_in;
                key_idx  <= '0;
                key_busy <= 1'b1;
            end else if (grant_key_c) begin
                key_out[{key_idx, 3'b000} +: 8] <= sbox_out_c;
                key_idx <= key_idx + 1'b1;
                if (key_idx == KEY_IDX_W'(KEY_BYTES - 1)) begin
                    key_busy <= 1'b0;
                    key_done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_key <= 1'b1;
        end else if (grant_key_c) begin
            last_key <= 1'b1;
        end else if (grant_blk_c) begin
            last_key <= 1'b0;
        end
    end

endmodule
